tweet_sched: RTL and testbench

//  Sequencer/arbiter for the tweetboard message RAM (16-bit words, bit15 = valid, [7:0] = ASCII).

---
 rtl/tweet_sched.sv | 214 +++++++++++++++++++++
 tb/tb_tweet_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tweet_sched.sv
// tweetboard message RAM sequencer: rx writer / playback reader / clear.
// Define AUTO_REPLAY_EN to add the replay_tick auto-playback input.
module tweet_sched #(
  parameter int ADDR_W = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              play_req,
  input  logic              clear_req,
  input  logic              char_tick,
  input  logic              tx_busy,
`ifdef AUTO_REPLAY_EN
  input  logic              replay_tick,
`endif
  input  logic [15:0]       ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              playing,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] PTR_END = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_CHECK,
    S_TX_WAIT, S_TX_HOLD, S_CLEAR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              skid_vld_q, skid_vld_d;
  logic [7:0]        skid_data_q, skid_data_d;
  logic              rvalid_q, rvalid_d;
  logic [7:0]        rchar_q, rchar_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              ovf_q, ovf_d;
  logic              clr_pend_q, clr_pend_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [1:0]        hold_cnt_q, hold_cnt_d;
  logic              hold_seen_q, hold_seen_d;

  logic drain;
  logic accept;
  logic start;
  logic unused_rdata;

  assign unused_rdata = ^ram_rdata[14:8];

  assign full  = (wr_ptr_q == PTR_END);
  // the skid may drain in any state but CLEAR; in RD_ISSUE it steals the port
  assign drain  = skid_vld_q && !full && (state_q != S_CLEAR);
  assign accept = !full && (!skid_vld_q || drain);

`ifdef AUTO_REPLAY_EN
  assign start = play_req || (replay_tick && (wr_ptr_q != '0));
`else
  assign start = play_req;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    rvalid_d    = rvalid_q;
    rchar_d     = rchar_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    ovf_d       = ovf_q;
    clr_pend_d  = clr_pend_q;
    clr_addr_d  = clr_addr_q;
    hold_cnt_d  = hold_cnt_q;
    hold_seen_d = hold_seen_q;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    if (drain) begin
      ram_we     = 1'b1;
      ram_addr   = wr_ptr_q[ADDR_W-1:0];
      ram_wdata  = {1'b1, 7'b0, skid_data_q};
      wr_ptr_d   = wr_ptr_q + 1'b1;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q && full) begin
      skid_vld_d = 1'b0;
      ovf_d      = 1'b1;
    end

    if (rx_valid) begin
      if (accept) begin
        skid_vld_d  = 1'b1;
        skid_data_d = rx_data;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (clear_req && state_q != S_IDLE && state_q != S_CLEAR)
      clr_pend_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (clear_req || clr_pend_q) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
          clr_pend_d = 1'b0;
        end else if (start) begin
          state_d  = S_RD_ISSUE;
          rd_ptr_d = '0;
        end
      end
      S_RD_ISSUE: begin
        if (!drain) begin
          ram_addr = rd_ptr_q[ADDR_W-1:0];
          state_d  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        rvalid_d = ram_rdata[15];
        rchar_d  = ram_rdata[7:0];
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (!rvalid_q || rd_ptr_q == wr_ptr_q) begin
          state_d = S_IDLE;
        end else begin
          tx_data_d = rchar_q;
          state_d   = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (char_tick && !tx_busy) begin
          tx_start_d  = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          hold_cnt_d  = '0;
          hold_seen_d = 1'b0;
          state_d     = S_TX_HOLD;
        end
      end
      S_TX_HOLD: begin
        // phase 1: wait for busy or a 4-cycle timeout; phase 2: wait for idle
        if (!hold_seen_q) begin
          if (tx_busy || hold_cnt_q == 2'd3) hold_seen_d = 1'b1;
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (!tx_busy) begin
          state_d = (rd_ptr_q == PTR_END) ? S_IDLE : S_RD_ISSUE;
        end
      end
      S_CLEAR: begin
        ram_we     = 1'b1;
        ram_addr   = clr_addr_q;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) begin
          state_d    = S_IDLE;
          wr_ptr_d   = '0;
          ovf_d      = 1'b0;
          skid_vld_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      rvalid_q    <= 1'b0;
      rchar_q     <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      ovf_q       <= 1'b0;
      clr_pend_q  <= 1'b0;
      clr_addr_q  <= '0;
      hold_cnt_q  <= '0;
      hold_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      rvalid_q    <= rvalid_d;
      rchar_q     <= rchar_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      ovf_q       <= ovf_d;
      clr_pend_q  <= clr_pend_d;
      clr_addr_q  <= clr_addr_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_seen_q <= hold_seen_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign overflow = ovf_q;
  assign playing  = (state_q == S_RD_ISSUE) || (state_q == S_RD_WAIT) ||
                    (state_q == S_CHECK)    || (state_q == S_TX_WAIT) ||
                    (state_q == S_TX_HOLD);

endmodule

// File: tb/tb_tweet_sched.sv
// Directed bench for tweet_sched (ADDR_W = 2, DEPTH = 4) with a RAM
// and transmitter model; AUTO_REPLAY_EN adds the replay scenario.
module tb_tweet_sched;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          play_req;
  logic          clear_req;
  logic          char_tick;
  logic          tx_busy;
  logic          replay_tick;
  logic [15:0]   ram_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          playing;
  logic          full;
  logic          overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int play_cyc;
  int busy_cnt = 0;
  logic [2:0] tick_cnt = '0;
  logic [15:0] mem [4] = '{default: 16'h0000};
  logic [7:0] txq [$];
  int txc [$];

  always #5 clk = ~clk;

  tweet_sched #(.ADDR_W(AW)) dut (
    .sysclk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .play_req(play_req), .clear_req(clear_req),
    .char_tick(char_tick), .tx_busy(tx_busy),
`ifdef AUTO_REPLAY_EN
    .replay_tick(replay_tick),
`endif
    .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .tx_data(tx_data),
    .tx_start(tx_start), .playing(playing),
    .full(full), .overflow(overflow)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tick_cnt <= tick_cnt + 3'd1;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (tx_start) busy_cnt <= 3;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  assign char_tick = (tick_cnt == 3'd7);
  assign tx_busy   = (busy_cnt != 0);

  always @(negedge clk) begin
    if (tx_start) begin
      txq.push_back(tx_data);
      txc.push_back(cyc);
    end
  end

  function automatic logic [7:0] qat(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = c;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_play();
    txq.delete();
    txc.delete();
    @(negedge clk);
    play_req = 1'b1;
    play_cyc = cyc;
    @(negedge clk);
    play_req = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!playing) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_vec++;
    if ({ram_we, ram_addr, ram_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_ram: got we=%b a=%0d d=%h want 0", ram_we, ram_addr, ram_wdata);
    end
    n_vec++;
    if ({tx_start, tx_data} !== '0) begin
      n_err++;
      $display("FAIL reset_tx: got start=%b data=%h want 0", tx_start, tx_data);
    end
    n_vec++;
    if ({playing, full, overflow} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000", {playing, full, overflow});
    end
    reset = 1'b0;
  endtask

  task automatic test_hi();
    bit ok;
    tick(2);
    send_char(8'h48);
    tick(9);
    send_char(8'h49);
    tick(3);
    n_vec++;
    if (mem[0] !== 16'h8048 || mem[1] !== 16'h8049) begin
      n_err++;
      $display("FAIL hi_ram: got %h %h want 8048 8049", mem[0], mem[1]);
    end
    pulse_play();
    wait_idle(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL hi_timeout: playing=%b want 0", playing);
    end
    n_vec++;
    if (txq.size() != 2 || qat(0) !== 8'h48 || qat(1) !== 8'h49) begin
      n_err++;
      $display("FAIL hi_tx: got n=%0d %h %h want 2 48 49", txq.size(), qat(0), qat(1));
    end
    n_vec++;
    if (txc.size() == 0 || txc[0] - play_cyc < 3) begin
      n_err++;
      $display("FAIL hi_latency: got %0d tx, first after %0d cycles want >=3",
               txc.size(), (txc.size() > 0) ? txc[0] - play_cyc : -1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    txq.delete();
    @(negedge clk);
    play_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h4A;
    @(negedge clk);
    play_req = 1'b0;
    rx_valid = 1'b0;
    n_vec++;
    if (ram_we !== 1'b1 || ram_addr !== 2'd2 || ram_wdata !== 16'h804A) begin
      n_err++;
      $display("FAIL arb_write: got we=%b a=%0d d=%h want 1 2 804a", ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk);
    n_vec++;
    if (ram_we !== 1'b0 || ram_addr !== 2'd0 || playing !== 1'b1) begin
      n_err++;
      $display("FAIL arb_read: got we=%b a=%0d play=%b want 0 0 1", ram_we, ram_addr, playing);
    end
    wait_idle(ok);
    n_vec++;
    if (!ok || txq.size() != 3 || qat(0) !== 8'h48 || qat(1) !== 8'h49 || qat(2) !== 8'h4A) begin
      n_err++;
      $display("FAIL arb_tx: got ok=%b n=%0d %h %h %h want 3 48 49 4a",
               ok, txq.size(), qat(0), qat(1), qat(2));
    end
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL arb_ovf: got %b want 0", overflow);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n_vec++;
    if (ram_we !== 1'b1 || ram_addr !== 2'd0 || ram_wdata !== 16'h0) begin
      n_err++;
      $display("FAIL clr_sweep: got we=%b a=%0d d=%h want 1 0 0", ram_we, ram_addr, ram_wdata);
    end
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(negedge clk);
    rx_data  = 8'h42;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clr_first: got ovf=%b want 0", overflow);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL clr_second: got ovf=%b want 1", overflow);
    end
    tick(3);
    n_vec++;
    if (overflow !== 1'b0 || full !== 1'b0 || playing !== 1'b0) begin
      n_err++;
      $display("FAIL clr_done: got ovf=%b full=%b play=%b want 000", overflow, full, playing);
    end
    n_vec++;
    if (mem[0] !== 16'h0 || mem[2] !== 16'h0 || mem[3] !== 16'h0) begin
      n_err++;
      $display("FAIL clr_ram: got %h %h %h want 0", mem[0], mem[2], mem[3]);
    end
    send_char(8'h58);
    tick(2);
    n_vec++;
    if (mem[0] !== 16'h8058 || mem[1] !== 16'h0) begin
      n_err++;
      $display("FAIL clr_wrptr: got %h %h want 8058 0000", mem[0], mem[1]);
    end
  endtask

  task automatic test_full();
    bit ok;
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      send_char(8'h61 + 8'(i));
      tick(2);
    end
    n_vec++;
    if (full !== 1'b0) begin
      n_err++;
      $display("FAIL full_early: got %b want 0", full);
    end
    send_char(8'h64);
    tick(2);
    n_vec++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_four: got full=%b ovf=%b want 1 0", full, overflow);
    end
    send_char(8'h65);
    n_vec++;
    if (overflow !== 1'b1 || mem[0] !== 16'h8061 || mem[3] !== 16'h8064) begin
      n_err++;
      $display("FAIL full_drop: got ovf=%b %h %h want 1 8061 8064", overflow, mem[0], mem[3]);
    end
    pulse_play();
    wait_idle(ok);
    n_vec++;
    if (!ok || txq.size() != 4 || qat(0) !== 8'h61 || qat(3) !== 8'h64) begin
      n_err++;
      $display("FAIL full_play: got ok=%b n=%0d %h %h want 4 61 64", ok, txq.size(), qat(0), qat(3));
    end
  endtask

  task automatic test_reset_hold();
    bit seen;
    bit ok;
    pulse_play();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL rh_start: tx_start=%b want 1 within 100 cycles", tx_start);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (playing !== 1'b0 || tx_start !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL rh_abort: got play=%b start=%b full=%b ovf=%b want 0000",
               playing, tx_start, full, overflow);
    end
    pulse_play();
    n_vec++;
    if (playing !== 1'b1 || ram_addr !== 2'd0 || ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL rh_replay: got play=%b a=%0d we=%b want 1 0 0", playing, ram_addr, ram_we);
    end
    wait_idle(ok);
    n_vec++;
    if (!ok || txq.size() != 0) begin
      n_err++;
      $display("FAIL rh_empty: got ok=%b n=%0d want 0 chars", ok, txq.size());
    end
  endtask

`ifdef AUTO_REPLAY_EN
  task automatic test_auto_replay();
    bit ok;
    txq.delete();
    @(negedge clk);
    replay_tick = 1'b1;
    @(negedge clk);
    replay_tick = 1'b0;
    n_vec++;
    if (playing !== 1'b0) begin
      n_err++;
      $display("FAIL ar_empty: got playing=%b want 0", playing);
    end
    tick(30);
    n_vec++;
    if (txq.size() != 0) begin
      n_err++;
      $display("FAIL ar_empty_tx: got %0d chars want 0", txq.size());
    end
    for (int i = 0; i < 3; i++) begin
      send_char(8'h78 + 8'(i));
      tick(2);
    end
    @(negedge clk);
    replay_tick = 1'b1;
    @(negedge clk);
    replay_tick = 1'b0;
    wait_idle(ok);
    n_vec++;
    if (!ok || txq.size() != 3 || qat(0) !== 8'h78 || qat(2) !== 8'h7A) begin
      n_err++;
      $display("FAIL ar_play: got ok=%b n=%0d %h %h want 3 78 7a", ok, txq.size(), qat(0), qat(2));
    end
  endtask
`endif

  initial begin
    rx_valid    = 1'b0;
    rx_data     = '0;
    play_req    = 1'b0;
    clear_req   = 1'b0;
    replay_tick = 1'b0;
    reset       = 1'b1;
    test_reset();
    test_hi();
    test_back_to_back();
    test_clear();
    test_full();
    test_reset_hold();
`ifdef AUTO_REPLAY_EN
    test_auto_replay();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
